pulse_channel_generator: RTL and testbench

PULSE_CHANNEL_GENERATOR -- requirements
Module: pulse_channel_generator

---
 rtl/pulse_channel_generator.sv | 116 +++++++++++
 tb/tb_pulse_channel_generator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_channel_generator.sv
// Square-wave tone channel: duty sequencer, volume envelope and length counter.
// O_SAMPLE lags I_STROBE by one cycle; O_ACTIVE is the live channel register, no backpressure.
module pulse_channel_generator #(
  parameter int SAMPLE_WIDTH = 20,
  parameter int FREQ_WIDTH   = 11,
  parameter int LENGTH_WIDTH = 6
) (
  input  logic                    I_BITCLK,
  input  logic                    I_RESET_N,
  input  logic                    I_STROBE,
  input  logic                    I_FREQ_TICK,
  input  logic                    I_LENGTH_TICK,
  input  logic                    I_ENV_TICK,
  input  logic                    I_TRIGGER,
  input  logic [FREQ_WIDTH-1:0]   I_FREQUENCY,
  input  logic [1:0]              I_DUTY_CYCLE,
  input  logic [3:0]              I_VOLUME,
  input  logic                    I_ENV_DIR,
  input  logic [2:0]              I_ENV_PERIOD,
  input  logic [LENGTH_WIDTH-1:0] I_LENGTH,
  input  logic                    I_LENGTH_EN,
  output logic [SAMPLE_WIDTH-1:0] O_SAMPLE,
  output logic                    O_ACTIVE
);

  localparam logic [SAMPLE_WIDTH-1:0] AMP_STEP =
    SAMPLE_WIDTH'(((64'd1 << (SAMPLE_WIDTH - 1)) - 64'd1) / 64'd15);
  localparam logic [FREQ_WIDTH:0]   TIMER_ONE = 1;
  localparam logic [LENGTH_WIDTH:0] LEN_ONE   = 1;

  logic                    active;
  logic [FREQ_WIDTH:0]     timer;
  logic [2:0]              step;
  logic [3:0]              vol;
  logic [2:0]              env_cnt;
  logic [LENGTH_WIDTH:0]   len_cnt;

  logic [FREQ_WIDTH:0]     period;
  logic [LENGTH_WIDTH:0]   len_load;
  logic [7:0]              pattern;
  logic                    wave_high;
  logic [SAMPLE_WIDTH-1:0] amp;
  logic [SAMPLE_WIDTH-1:0] amp_neg;

  assign period   = {1'b1, {FREQ_WIDTH{1'b0}}} - {1'b0, I_FREQUENCY};
  assign len_load = {1'b1, {LENGTH_WIDTH{1'b0}}} - {1'b0, I_LENGTH};

  always_comb begin
    pattern = 8'b0000_0001;
    case (I_DUTY_CYCLE)
      2'b00:   pattern = 8'b0000_0001;
      2'b01:   pattern = 8'b1000_0001;
      2'b10:   pattern = 8'b1000_0111;
      default: pattern = 8'b0111_1110;
    endcase
  end

  assign wave_high = pattern[step];
  assign amp       = SAMPLE_WIDTH'(vol) * AMP_STEP;
  assign amp_neg   = -amp;
  assign O_ACTIVE  = active;

  always_ff @(posedge I_BITCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      active   <= 1'b0;
      timer    <= '0;
      step     <= '0;
      vol      <= '0;
      env_cnt  <= '0;
      len_cnt  <= '0;
      O_SAMPLE <= '0;
    end else begin
      // Sample reflects the state seen at this edge, before any update below.
      if (I_STROBE)
        O_SAMPLE <= !active ? '0 : (wave_high ? amp : amp_neg);

      if (I_TRIGGER) begin
        // A silent, non-rising envelope keeps the DAC off.
        active  <= !(I_VOLUME == 4'd0 && !I_ENV_DIR);
        timer   <= period;
        step    <= '0;
        vol     <= I_VOLUME;
        env_cnt <= I_ENV_PERIOD;
        len_cnt <= len_load;
      end else begin
        if (active && I_FREQ_TICK) begin
          if (timer == TIMER_ONE) begin
            timer <= period;
            step  <= step + 3'd1;
          end else begin
            timer <= timer - TIMER_ONE;
          end
        end

        if (active && I_ENV_TICK && I_ENV_PERIOD != 3'd0) begin
          if (env_cnt <= 3'd1) begin
            env_cnt <= I_ENV_PERIOD;
            if (I_ENV_DIR && vol != 4'd15)
              vol <= vol + 4'd1;
            else if (!I_ENV_DIR && vol != 4'd0)
              vol <= vol - 4'd1;
          end else begin
            env_cnt <= env_cnt - 3'd1;
          end
        end

        if (I_LENGTH_TICK && I_LENGTH_EN && len_cnt != '0) begin
          len_cnt <= len_cnt - LEN_ONE;
          if (len_cnt == LEN_ONE)
            active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_channel_generator.sv
// Directed bench for pulse_channel_generator with an expectation queue drained after each edge.
module tb_pulse_channel_generator;

  localparam int SW = 20;
  localparam int FW = 11;
  localparam int LW = 6;
  localparam int AMP = ((1 << (SW - 1)) - 1) / 15;
  localparam logic [SW-1:0] MAX_POS = 20'h7FFF8;
  localparam logic [SW-1:0] MAX_NEG = 20'h80008;

  logic          I_BITCLK = 1'b0;
  logic          I_RESET_N;
  logic          I_STROBE, I_FREQ_TICK, I_LENGTH_TICK, I_ENV_TICK, I_TRIGGER;
  logic [FW-1:0] I_FREQUENCY;
  logic [1:0]    I_DUTY_CYCLE;
  logic [3:0]    I_VOLUME;
  logic          I_ENV_DIR;
  logic [2:0]    I_ENV_PERIOD;
  logic [LW-1:0] I_LENGTH;
  logic          I_LENGTH_EN;
  logic [SW-1:0] O_SAMPLE;
  logic          O_ACTIVE;

  pulse_channel_generator #(.SAMPLE_WIDTH(SW), .FREQ_WIDTH(FW), .LENGTH_WIDTH(LW)) dut (
    .I_BITCLK(I_BITCLK), .I_RESET_N(I_RESET_N), .I_STROBE(I_STROBE),
    .I_FREQ_TICK(I_FREQ_TICK), .I_LENGTH_TICK(I_LENGTH_TICK), .I_ENV_TICK(I_ENV_TICK),
    .I_TRIGGER(I_TRIGGER), .I_FREQUENCY(I_FREQUENCY), .I_DUTY_CYCLE(I_DUTY_CYCLE),
    .I_VOLUME(I_VOLUME), .I_ENV_DIR(I_ENV_DIR), .I_ENV_PERIOD(I_ENV_PERIOD),
    .I_LENGTH(I_LENGTH), .I_LENGTH_EN(I_LENGTH_EN), .O_SAMPLE(O_SAMPLE), .O_ACTIVE(O_ACTIVE)
  );

  always #5 I_BITCLK = ~I_BITCLK;

  int n_checks = 0;
  int n_pass   = 0;

  string         q_tag[$];
  bit            q_is_act[$];
  logic [SW-1:0] q_val[$];

  task automatic compare(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic exp_sample(input string tag, input logic [SW-1:0] v);
    q_tag.push_back(tag); q_is_act.push_back(1'b0); q_val.push_back(v);
  endtask

  task automatic exp_active(input string tag, input logic a);
    q_tag.push_back(tag); q_is_act.push_back(1'b1); q_val.push_back({{(SW-1){1'b0}}, a});
  endtask

  task automatic drain();
    string         tag;
    bit            is_act;
    logic [SW-1:0] v;
    while (q_tag.size() > 0) begin
      tag    = q_tag.pop_front();
      is_act = q_is_act.pop_front();
      v      = q_val.pop_front();
      compare(tag, is_act ? {{(SW-1){1'b0}}, O_ACTIVE} : O_SAMPLE, v);
    end
  endtask

  task automatic clk_check();
    @(posedge I_BITCLK);
    #1;
    drain();
  endtask

  function automatic logic [SW-1:0] vol_amp(input int v);
    return SW'(v * AMP);
  endfunction

  initial begin
    logic [7:0] pat50;
    int         pos_cnt;
    int         v;

    pat50 = 8'b1000_0111;
    I_RESET_N = 1'b0;
    {I_STROBE, I_FREQ_TICK, I_LENGTH_TICK, I_ENV_TICK, I_TRIGGER} = '0;
    I_FREQUENCY = '0; I_DUTY_CYCLE = '0; I_VOLUME = '0; I_ENV_DIR = 1'b0;
    I_ENV_PERIOD = '0; I_LENGTH = '0; I_LENGTH_EN = 1'b0;

    #12;
    exp_sample("reset_sample", '0);
    exp_active("reset_active", 1'b0);
    drain();
    I_RESET_N = 1'b1;
    clk_check();

    // 50% duty, period 2 ticks, full volume
    I_FREQUENCY = 11'd2046; I_DUTY_CYCLE = 2'b10; I_VOLUME = 4'd15;
    I_TRIGGER = 1'b1;
    exp_active("dutyA_trig_active", 1'b1);
    clk_check();
    I_TRIGGER = 1'b0; I_FREQ_TICK = 1'b1; I_STROBE = 1'b1;
    pos_cnt = 0;
    for (int n = 0; n < 32; n++) begin
      exp_sample("dutyA_sample", pat50[(n / 2) % 8] ? MAX_POS : MAX_NEG);
      clk_check();
      if (O_SAMPLE === MAX_POS) pos_cnt++;
    end
    compare("dutyA_high_count", SW'(pos_cnt), SW'(16));
    I_FREQ_TICK = 1'b0; I_STROBE = 1'b0;

    // Decreasing envelope, period 2, from volume 8
    I_DUTY_CYCLE = 2'b00; I_VOLUME = 4'd8; I_ENV_DIR = 1'b0; I_ENV_PERIOD = 3'd2;
    I_TRIGGER = 1'b1;
    exp_active("envB_trig_active", 1'b1);
    clk_check();
    I_TRIGGER = 1'b0; I_ENV_TICK = 1'b1; I_STROBE = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      v = 8 - (n - 1) / 2;
      if (v < 0) v = 0;
      exp_sample("envB_sample", vol_amp(v));
      exp_active("envB_active", 1'b1);
      clk_check();
    end
    I_ENV_TICK = 1'b0; I_STROBE = 1'b0; I_ENV_PERIOD = 3'd0;

    // Length expiry after 4 ticks (64 - 60)
    I_VOLUME = 4'd15; I_LENGTH = 6'd60; I_LENGTH_EN = 1'b1;
    I_TRIGGER = 1'b1;
    clk_check();
    I_TRIGGER = 1'b0; I_STROBE = 1'b1;
    exp_sample("lenC_sample_pre", MAX_POS);
    clk_check();
    I_STROBE = 1'b0; I_LENGTH_TICK = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      exp_active("lenC_active", k < 4);
      exp_sample("lenC_sample_hold", MAX_POS);
      clk_check();
    end
    I_LENGTH_TICK = 1'b0; I_STROBE = 1'b1;
    exp_sample("lenC_sample_off", '0);
    exp_active("lenC_active_off", 1'b0);
    clk_check();
    I_STROBE = 1'b0;

    // Trigger coincident with the expiring length tick
    I_TRIGGER = 1'b1;
    exp_active("lenD_trig_active", 1'b1);
    clk_check();
    I_TRIGGER = 1'b0; I_LENGTH_TICK = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_active("lenD_pre_active", 1'b1);
      clk_check();
    end
    I_TRIGGER = 1'b1;
    exp_active("lenD_collide_active", 1'b1);
    clk_check();
    I_TRIGGER = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_active("lenD_reload_active", k < 4);
      clk_check();
    end
    I_LENGTH_TICK = 1'b0; I_LENGTH_EN = 1'b0;

    // Zero volume with falling envelope keeps the DAC off
    I_TRIGGER = 1'b1;
    clk_check();
    I_TRIGGER = 1'b0; I_STROBE = 1'b1;
    exp_sample("volE_sample_on", MAX_POS);
    clk_check();
    I_STROBE = 1'b0; I_VOLUME = 4'd0; I_ENV_DIR = 1'b0; I_TRIGGER = 1'b1;
    exp_active("volE_active", 1'b0);
    exp_sample("volE_sample_hold", MAX_POS);
    clk_check();
    I_TRIGGER = 1'b0; I_STROBE = 1'b1;
    exp_sample("volE_sample_zero", '0);
    exp_active("volE_active_after", 1'b0);
    clk_check();
    I_STROBE = 1'b0;

    // Asynchronous reset between edges while running
    I_VOLUME = 4'd15; I_TRIGGER = 1'b1;
    clk_check();
    I_TRIGGER = 1'b0; I_STROBE = 1'b1;
    exp_sample("rstF_sample_pre", MAX_POS);
    exp_active("rstF_active_pre", 1'b1);
    clk_check();
    I_STROBE = 1'b0;
    #3;
    I_RESET_N = 1'b0;
    #1;
    exp_sample("rstF_sample_async", '0);
    exp_active("rstF_active_async", 1'b0);
    drain();
    #2;
    I_RESET_N = 1'b1;
    clk_check();
    I_STROBE = 1'b1; I_FREQ_TICK = 1'b1; I_ENV_TICK = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_sample("rstF_idle_sample", '0);
      exp_active("rstF_idle_active", 1'b0);
      clk_check();
    end
    I_TRIGGER = 1'b1;
    exp_sample("rstF_retrig_sample", '0);
    exp_active("rstF_retrig_active", 1'b1);
    clk_check();
    I_TRIGGER = 1'b0;
    exp_sample("rstF_run_sample", MAX_POS);
    clk_check();
    I_STROBE = 1'b0; I_FREQ_TICK = 1'b0; I_ENV_TICK = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
